// File: rtl/scaler_div_fix.sv
// Registered signed divide-by-2^SCALE with a parameter-selected rounding rule.
// The result is captured one cycle after the operand and is flagged by out_valid.
module scaler_div_fix #(
  parameter int WIDTH      = 8,
  parameter int SCALE      = 2,
  parameter int ROUND_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out
);

  logic signed [WIDTH-1:0] result;

  if (SCALE < 0 || SCALE > WIDTH - 1) begin : g_bad_scale
    $error("scaler_div_fix: SCALE must lie in 0..WIDTH-1");
  end

  if (ROUND_MODE < 0 || ROUND_MODE > 2) begin : g_bad_mode
    $error("scaler_div_fix: ROUND_MODE must be 0, 1 or 2");
  end

  if (SCALE == 0) begin : g_pass
    assign result = in;
  end else begin : g_div
    logic signed [WIDTH-1:0] q;
    logic        [SCALE-1:0] frac;
    logic        [SCALE-1:0] half;
    logic                    neg;
    logic                    bump;

    assign q    = in >>> SCALE;
    assign frac = in[SCALE-1:0];
    assign neg  = in[WIDTH-1];

    always_comb begin
      half = '0;
      half[SCALE-1] = 1'b1;
    end

    // The shift already floors, so every mode only ever needs a +1 correction.
    always_comb begin
      bump = 1'b0;
      case (ROUND_MODE)
        0:       bump = neg && (frac != '0);
        1:       bump = 1'b0;
        default: bump = neg ? (frac > half) : (frac >= half);
      endcase
    end

    // |q|+1 always fits in WIDTH bits once SCALE>=1, so the carry-out is never needed.
    assign result = q + WIDTH'(bump);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= result;
      end
    end
  end

endmodule

// File: tb/tb_scaler_div_fix.sv
// Drives several scaler_div_fix configurations from one operand stream and
// compares every output against an integer-arithmetic reference each cycle.
module tb_scaler_div_fix;

  localparam int N = 6;
  localparam int SCALES [N] = '{2, 2, 2, 0, 7, 1};
  localparam int MODES  [N] = '{0, 1, 2, 0, 0, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in = 8'h00;
  logic [7:0] outs [N];
  logic       ovs  [N];

  logic [7:0] exp_out [N];
  logic       exp_valid = 1'b0;
  logic       checking = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  scaler_div_fix #(.WIDTH(8), .SCALE(2), .ROUND_MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .out_valid(ovs[0]), .out(outs[0]));
  scaler_div_fix #(.WIDTH(8), .SCALE(2), .ROUND_MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .out_valid(ovs[1]), .out(outs[1]));
  scaler_div_fix #(.WIDTH(8), .SCALE(2), .ROUND_MODE(2)) u_m2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .out_valid(ovs[2]), .out(outs[2]));
  scaler_div_fix #(.WIDTH(8), .SCALE(0), .ROUND_MODE(0)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .out_valid(ovs[3]), .out(outs[3]));
  scaler_div_fix #(.WIDTH(8), .SCALE(7), .ROUND_MODE(0)) u_s7 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .out_valid(ovs[4]), .out(outs[4]));
  scaler_div_fix #(.WIDTH(8), .SCALE(1), .ROUND_MODE(2)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .out_valid(ovs[5]), .out(outs[5]));

  // Reference quotient from plain integer division on the signed value.
  function automatic logic [7:0] ref_div(input logic [7:0] v, input int s, input int mode);
    int x;
    int d;
    int r;
    x = int'($signed(v));
    d = 1 << s;
    if (s == 0) r = x;
    else begin
      case (mode)
        0:       r = x / d;
        1:       r = (x >= 0) ? x / d : -((-x + d - 1) / d);
        default: r = (x >= 0) ? (x + d / 2) / d : -((-x + d / 2) / d);
      endcase
    end
    return r[7:0];
  endfunction

  task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] v, input logic vld, input logic r);
    in       = v;
    in_valid = vld;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  // Expected register contents, updated from what the DUTs sample at each edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_valid = 1'b0;
      for (int i = 0; i < N; i++) exp_out[i] = 8'h00;
    end else begin
      exp_valid = in_valid;
      if (in_valid)
        for (int i = 0; i < N; i++) exp_out[i] = ref_div(in, SCALES[i], MODES[i]);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < N; i++) begin
        check_output($sformatf("valid[%0d]", i), {7'b0, ovs[i]}, {7'b0, exp_valid});
        check_output($sformatf("out[%0d]", i), outs[i], exp_out[i]);
      end
    end
  end

  typedef struct {
    logic [7:0] v;
    int         inst;
    logic [7:0] want;
  } lit_t;

  lit_t lits [] = '{
    '{8'h08, 0, 8'h02}, '{8'h88, 0, 8'hE2}, '{8'h01, 0, 8'h00}, '{8'h81, 0, 8'hE1},
    '{8'h00, 0, 8'h00}, '{8'hFF, 0, 8'h00}, '{8'h80, 0, 8'hE0}, '{8'h7F, 0, 8'h1F},
    '{8'h08, 1, 8'h02}, '{8'h88, 1, 8'hE2}, '{8'h01, 1, 8'h00}, '{8'h81, 1, 8'hE0},
    '{8'h00, 1, 8'h00}, '{8'hFF, 1, 8'hFF}, '{8'h80, 1, 8'hE0},
    '{8'h02, 2, 8'h01}, '{8'hFE, 2, 8'hFF}, '{8'h81, 2, 8'hE0}, '{8'h7F, 2, 8'h20},
    '{8'h01, 2, 8'h00}, '{8'hFF, 2, 8'h00}, '{8'h80, 2, 8'hE0},
    '{8'h81, 3, 8'h81}, '{8'h80, 4, 8'hFF}, '{8'h7F, 4, 8'h00},
    '{8'h03, 5, 8'h02}, '{8'hFD, 5, 8'hFE}, '{8'hFF, 5, 8'hFF}
  };

  initial begin
    logic [7:0] v;

    // Pin the reference model itself against hand-worked quotients.
    check_output("model m0 0x81", ref_div(8'h81, 2, 0), 8'hE1);
    check_output("model m1 0x81", ref_div(8'h81, 2, 1), 8'hE0);
    check_output("model m2 0xFE", ref_div(8'hFE, 2, 2), 8'hFF);
    check_output("model s7 0x80", ref_div(8'h80, 7, 0), 8'hFF);

    apply_stimulus(8'h00, 1'b0, 1'b1);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    checking = 1'b1;
    check_output("reset out", outs[0], 8'h00);
    check_output("reset valid", {7'b0, ovs[0]}, 8'h00);

    foreach (lits[k]) begin
      apply_stimulus(lits[k].v, 1'b1, 1'b0);
      check_output($sformatf("vec 0x%02h inst %0d", lits[k].v, lits[k].inst),
                   outs[lits[k].inst], lits[k].want);
      check_output("vec valid", {7'b0, ovs[lits[k].inst]}, 8'h01);
    end

    apply_stimulus(8'h08, 1'b1, 1'b0);
    check_output("gap first", outs[0], 8'h02);
    apply_stimulus(8'h88, 1'b0, 1'b0);
    check_output("gap valid low", {7'b0, ovs[0]}, 8'h00);
    check_output("gap hold", outs[0], 8'h02);
    apply_stimulus(8'h81, 1'b1, 1'b0);
    check_output("gap resume", outs[0], 8'hE1);
    check_output("gap resume valid", {7'b0, ovs[0]}, 8'h01);

    apply_stimulus(8'h08, 1'b1, 1'b1);
    check_output("midreset out", outs[0], 8'h00);
    check_output("midreset valid", {7'b0, ovs[0]}, 8'h00);
    apply_stimulus(8'h88, 1'b1, 1'b0);
    check_output("post reset out", outs[0], 8'hE2);
    check_output("post reset valid", {7'b0, ovs[0]}, 8'h01);

    for (int c = 0; c < 2000; c++) begin
      case ($urandom_range(0, 7))
        0:       v = 8'h80;
        1:       v = 8'h7F;
        2:       v = 8'h00;
        default: v = 8'($urandom);
      endcase
      apply_stimulus(v, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
